console_tx_fifo: RTL and testbench
==================================

// Module: console_tx_fifo
// PURPOSE
//  Byte-buffering bridge between the CPU data-bus Wishbone (slave side) and the
//  console sink (master side). CPU stores to the DATA register push bytes into a
//  FIFO, and a drain FSM forwards them one at a time to the console's stb/ack port.
//  The CPU can read a STATUS register to poll the fill level.
// PARAMETERS
//  DEPTH  16  FIFO entries; power of 2, 2..128. CW = $clog2(DEPTH)+1 count bits.
// PORTS
//  i_clk        in   1   clock
//  i_reset      in   1   synchronous, active-high reset
//  i_wb_stb     in   1   CPU request strobe
//  i_wb_we      in   1   1 = write, 0 = read
//  i_wb_addr    in   1   0 = DATA, 1 = STATUS
//  i_wb_data    in   32  write data; DATA uses [7:0] only
//  o_wb_data    out  32  read data; valid while o_wb_ack = 1
//  o_wb_ack     out  1   one-cycle acknowledge
//  o_wb_stall   out  1   request not accepted this cycle
//  o_con_stb    out  1   console strobe
//  o_con_data   out  32  {24'b0, byte}
//  i_con_ack    in   1   console acknowledge
//  i_con_stall  in   1   console stall
// BEHAVIOUR
//  Reset: all pointers, count, overflow, FSM=IDLE; o_wb_ack, o_wb_data, o_con_stb,
//   o_con_data all 0. Reset mid-transfer abandons it; o_con_stb is 0 the next cycle.
//  Slave side:
//   - Accept = i_wb_stb && !o_wb_stall.
//   - o_wb_ack=1 exactly one cycle after accept, else 0. Reads are registered and
//     o_wb_data is sampled at the accept cycle.
//   - o_wb_stall is combinational = i_wb_stb && i_wb_we && addr==0 && full.
//     A pop in the same cycle does not un-stall the request.
//   - DATA write: push i_wb_data[7:0]. DATA read: returns 0.
//   - STATUS read: {16'b0, count[7:0], 5'b0, ovf, full, empty}.
//   - STATUS write: data[2]=1 clears ovf. Other bits are ignored. Always acked.
//  FIFO: circular RAM, wrap at DEPTH. count = pushes - pops, range 0..DEPTH.
//   full  = (count == DEPTH); empty = (count == 0).
//   Simultaneous push and pop leaves count unchanged.
//  Drain FSM:
//   - IDLE: if !empty, load o_con_data from head, set o_con_stb=1, go to REQ.
//   - REQ: hold o_con_stb and o_con_data stable while i_con_stall=1. When
//     i_con_stall=0, clear o_con_stb next cycle, pop the head, go to WAIT.
//   - WAIT: on i_con_ack go to IDLE. i_con_ack outside WAIT is ignored.
//   - Minimum 3 cycles per byte; byte order = push order.
// CONFIGURATION
//  CONSOLE_TX_OVERFLOW_DROP_EN:
//   - Defined: o_wb_stall is tied 0. A DATA write while full is acked but the byte
//     is dropped, and sticky ovf is set to 1.
//   - Undefined: full-FIFO writes stall (as above), and ovf reads as 0.
// TESTING
//  1. Reset, then STATUS read -> ack 1 cycle later, o_wb_data=32'h0000_0001.
//  2. DATA writes 0x48, 0x69 back-to-back; console acks 1 cycle after stb ->
//     o_con_data=0x48 then 0x69; STATUS then reads 0x0000_0001.
//  3. DEPTH=4, i_con_stall held 1, 5 DATA writes -> 5th is stalled, STATUS reads
//     0x0000_0402; drop stall -> 4 bytes drained in order, then the 5th accepted.
//  4. i_con_stall=1 for 3 cycles during REQ -> o_con_stb=1 and o_con_data
//     unchanged for all 3 cycles, exactly one pop afterwards.
//  5. DROP_EN, DEPTH=4, console stalled, 5 writes -> 5 acks, no stall, STATUS
//     reads 0x0000_0406; write STATUS 0x4 -> STATUS reads 0x0000_0402.
//  6. Assert i_reset while in REQ with 3 queued bytes -> next cycle o_con_stb=0,
//     STATUS read reads 0x0000_0001; a late i_con_ack causes no pop.

Source files
------------

// File: rtl/console_tx_fifo.sv
// rtl/console_tx_fifo.sv - Wishbone-fed byte FIFO draining to the console stb/ack port.
// Optional CONSOLE_TX_OVERFLOW_DROP_EN: full-FIFO writes are acked and dropped, setting sticky ovf.
module console_tx_fifo #(
   parameter int DEPTH = 16
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_wb_stb,
   input  logic        i_wb_we,
   input  logic        i_wb_addr,
   input  logic [31:0] i_wb_data,
   output logic [31:0] o_wb_data,
   output logic        o_wb_ack,
   output logic        o_wb_stall,
   output logic        o_con_stb,
   output logic [31:0] o_con_data,
   input  logic        i_con_ack,
   input  logic        i_con_stall
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;
   state_t state, state_next;

   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] count;
   logic          ovf, full, empty, is_data, accept, push, pop, load;
   logic          ovf_set, ovf_clr;
   logic [31:0]   status_word;
   logic          unused_wb_data;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign is_data = (i_wb_addr == 1'b0);

`ifdef CONSOLE_TX_OVERFLOW_DROP_EN
   assign o_wb_stall = 1'b0;
   assign ovf_set    = accept && i_wb_we && is_data && full;
   assign ovf_clr    = accept && i_wb_we && !is_data && i_wb_data[2];
`else
   // Stall looks at the registered fill level, so a same-cycle pop never frees the slot.
   assign o_wb_stall = i_wb_stb && i_wb_we && is_data && full;
   assign ovf_set    = 1'b0;
   assign ovf_clr    = 1'b0;
`endif

   assign accept         = i_wb_stb && !o_wb_stall;
   assign push           = accept && i_wb_we && is_data && !full;
   assign status_word    = {16'h0, 8'(count), 5'h0, ovf, full, empty};
   assign unused_wb_data = ^i_wb_data[31:8];

   always_ff @(posedge i_clk) begin
      if (push)
         mem[wr_ptr] <= i_wb_data[7:0];
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         ovf    <= 1'b0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (ovf_set)
            ovf <= 1'b1;
         else if (ovf_clr)
            ovf <= 1'b0;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         o_wb_ack  <= 1'b0;
         o_wb_data <= 32'h0;
      end else begin
         o_wb_ack  <= accept;
         o_wb_data <= (accept && !i_wb_we && !is_data) ? status_word : 32'h0;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state      <= S_IDLE;
         o_con_data <= 32'h0;
      end else begin
         state <= state_next;
         if (load)
            o_con_data <= {24'h0, mem[rd_ptr]};
      end
   end

   // The head is popped as soon as the console takes the strobe; the ack only releases WAIT.
   always_comb begin
      state_next = state;
      pop        = 1'b0;
      load       = 1'b0;
      case (state)
         S_IDLE: begin
            if (!empty) begin
               load       = 1'b1;
               state_next = S_REQ;
            end
         end
         S_REQ: begin
            if (!i_con_stall) begin
               pop        = 1'b1;
               state_next = S_WAIT;
            end
         end
         S_WAIT: begin
            if (i_con_ack)
               state_next = S_IDLE;
         end
         default: state_next = S_IDLE;
      endcase
   end

   assign o_con_stb = (state == S_REQ);
endmodule

// File: tb/tb_console_tx_fifo.sv
// tb/tb_console_tx_fifo.sv - Self-checking bench for console_tx_fifo (DEPTH=4), queue-based scoreboard.
module tb_console_tx_fifo;
   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        wb_stb, wb_we, wb_addr;
   logic [31:0] wb_wdata, wb_rdata;
   logic        wb_ack, wb_stall;
   logic        con_stb;
   logic [31:0] con_data;
   logic        con_ack, con_stall;

   console_tx_fifo #(.DEPTH(DEPTH)) dut (
      .i_clk       (clk),
      .i_reset     (rst),
      .i_wb_stb    (wb_stb),
      .i_wb_we     (wb_we),
      .i_wb_addr   (wb_addr),
      .i_wb_data   (wb_wdata),
      .o_wb_data   (wb_rdata),
      .o_wb_ack    (wb_ack),
      .o_wb_stall  (wb_stall),
      .o_con_stb   (con_stb),
      .o_con_data  (con_data),
      .i_con_ack   (con_ack),
      .i_con_stall (con_stall)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model: the FIFO contents as a queue, plus console handshake bookkeeping.
   logic [7:0] q[$];
   logic [7:0] sent[$];
   bit  m_ovf;
   bit  waiting;
   int  ack_cnt;
   int  stall_mode;   // 0 never, 1 always, 2 random
   int  ack_max;
   bit  force_ack;
   logic        obs_stall, obs_ack;
   logic [31:0] obs_rdata;

   typedef struct {
      logic        we;
      logic        addr;
      logic [31:0] wd;
      logic        exp_stall;
      logic        exp_ack;
      logic [31:0] exp_rd;
   } vec_t;
   vec_t tbl[11];

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // One bus cycle, entered and left at a falling edge.
   task automatic op(input logic stb, input logic we, input logic addr, input logic [31:0] d);
      logic        full, empty, exp_stall, acc, do_pop;
      logic [31:0] exp_rd;
      wb_stb    = stb;
      wb_we     = we;
      wb_addr   = addr;
      wb_wdata  = d;
      con_stall = (stall_mode == 0) ? 1'b0 : (stall_mode == 1) ? 1'b1 : 1'($urandom_range(1, 0));
      con_ack   = force_ack || (waiting && ack_cnt == 0);
      if (waiting && ack_cnt > 0)
         ack_cnt--;
      #1;
      full  = (q.size() == DEPTH);
      empty = (q.size() == 0);
`ifdef CONSOLE_TX_OVERFLOW_DROP_EN
      exp_stall = 1'b0;
`else
      exp_stall = stb && we && !addr && full;
`endif
      obs_stall = wb_stall;
      check32("wb_stall", {31'h0, wb_stall}, {31'h0, exp_stall});
      acc    = stb && !exp_stall;
      exp_rd = (acc && !we && addr) ? {16'h0, 8'(q.size()), 5'h0, m_ovf, full, empty} : 32'h0;
      check32("con_stb_in_wait", {31'h0, con_stb && waiting}, 32'h0);
      if (con_ack)
         waiting = 1'b0;
      do_pop = 1'b0;
      if (con_stb && !con_stall) begin
         if (q.size() == 0)
            check32("con_xfer_unexpected", con_data, 32'hxxxx_xxxx);
         else
            check32("con_data", con_data, {24'h0, q[0]});
         do_pop  = 1'b1;
         waiting = 1'b1;
         ack_cnt = $urandom_range(ack_max, 0);
         sent.push_back(con_data[7:0]);
      end
      if (do_pop && q.size() > 0)
         void'(q.pop_front());
      if (acc && we && !addr) begin
         if (!full)
            q.push_back(d[7:0]);
         else
            m_ovf = 1'b1;
      end
`ifdef CONSOLE_TX_OVERFLOW_DROP_EN
      if (acc && we && addr && d[2])
         m_ovf = 1'b0;
`endif
      @(posedge clk);
      @(negedge clk);
      obs_ack   = wb_ack;
      obs_rdata = wb_rdata;
      check32("wb_ack", {31'h0, wb_ack}, {31'h0, acc});
      if (acc)
         check32("wb_rdata", wb_rdata, exp_rd);
   endtask

   task automatic idle();
      op(1'b0, 1'b0, 1'b0, 32'h0);
   endtask

   task automatic drain();
      for (int i = 0; i < 300 && (q.size() > 0 || waiting); i++)
         idle();
      check32("drain_done", {31'h0, (q.size() > 0 || waiting)}, 32'h0);
   endtask

   task automatic do_reset();
      rst      = 1'b1;
      wb_stb   = 1'b0;
      wb_we    = 1'b0;
      wb_addr  = 1'b0;
      wb_wdata = 32'h0;
      con_ack  = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      q.delete();
      m_ovf   = 1'b0;
      waiting = 1'b0;
      ack_cnt = 0;
   endtask

   task automatic wait_stb();
      for (int i = 0; i < 20 && !con_stb; i++)
         idle();
      check32("stb_seen", {31'h0, con_stb}, 32'h1);
   endtask

   initial begin
      int base;
      stall_mode = 0;
      ack_max    = 0;
      force_ack  = 1'b0;
      con_stall  = 1'b0;
      @(negedge clk);
      do_reset();
      check32("rst_con_stb", {31'h0, con_stb}, 32'h0);
      check32("rst_con_data", con_data, 32'h0);
      check32("rst_wb_ack", {31'h0, wb_ack}, 32'h0);
      check32("rst_wb_data", wb_rdata, 32'h0);

      // Fill a stalled console past full, then inspect and clear status.
      tbl[0] = '{1'b0, 1'b1, 32'h0,  1'b0, 1'b1, 32'h0000_0001};
      tbl[1] = '{1'b1, 1'b0, 32'h10, 1'b0, 1'b1, 32'h0};
      tbl[2] = '{1'b1, 1'b0, 32'h11, 1'b0, 1'b1, 32'h0};
      tbl[3] = '{1'b1, 1'b0, 32'h12, 1'b0, 1'b1, 32'h0};
      tbl[4] = '{1'b1, 1'b0, 32'h13, 1'b0, 1'b1, 32'h0};
      tbl[5] = '{1'b0, 1'b1, 32'h0,  1'b0, 1'b1, 32'h0000_0402};
`ifdef CONSOLE_TX_OVERFLOW_DROP_EN
      tbl[6] = '{1'b1, 1'b0, 32'h14, 1'b0, 1'b1, 32'h0};
      tbl[7] = '{1'b0, 1'b1, 32'h0,  1'b0, 1'b1, 32'h0000_0406};
`else
      tbl[6] = '{1'b1, 1'b0, 32'h14, 1'b1, 1'b0, 32'h0};
      tbl[7] = '{1'b0, 1'b1, 32'h0,  1'b0, 1'b1, 32'h0000_0402};
`endif
      tbl[8]  = '{1'b1, 1'b1, 32'h4, 1'b0, 1'b1, 32'h0};
      tbl[9]  = '{1'b0, 1'b1, 32'h0, 1'b0, 1'b1, 32'h0000_0402};
      tbl[10] = '{1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0};
      stall_mode = 1;
      for (int i = 0; i < 11; i++) begin
         op(1'b1, tbl[i].we, tbl[i].addr, tbl[i].wd);
         check32($sformatf("tbl%0d_stall", i), {31'h0, obs_stall}, {31'h0, tbl[i].exp_stall});
         check32($sformatf("tbl%0d_ack", i), {31'h0, obs_ack}, {31'h0, tbl[i].exp_ack});
         if (tbl[i].exp_ack)
            check32($sformatf("tbl%0d_rdata", i), obs_rdata, tbl[i].exp_rd);
      end
      stall_mode = 0;
      drain();
      op(1'b1, 1'b1, 1'b0, 32'h14);
      drain();
      check32("fill_xfers", sent.size(), 5);
      for (int i = 0; i < 5 && i < sent.size(); i++)
         check32($sformatf("fill_order%0d", i), {24'h0, sent[i]}, 32'h10 + i);

      // Two back-to-back bytes, console acking immediately.
      sent.delete();
      op(1'b1, 1'b1, 1'b0, 32'h48);
      op(1'b1, 1'b1, 1'b0, 32'h69);
      drain();
      check32("hi_count", sent.size(), 2);
      if (sent.size() == 2) begin
         check32("hi_byte0", {24'h0, sent[0]}, 32'h48);
         check32("hi_byte1", {24'h0, sent[1]}, 32'h69);
      end
      op(1'b1, 1'b0, 1'b1, 32'h0);
      check32("hi_status", obs_rdata, 32'h0000_0001);

      // Console stall held during REQ: strobe and data must stay put.
      stall_mode = 1;
      op(1'b1, 1'b1, 1'b0, 32'hA5);
      wait_stb();
      for (int i = 0; i < 3; i++) begin
         idle();
         check32("hold_stb", {31'h0, con_stb}, 32'h1);
         check32("hold_data", con_data, 32'h0000_00A5);
      end
      stall_mode = 0;
      base = sent.size();
      drain();
      check32("hold_one_pop", sent.size() - base, 1);
      op(1'b1, 1'b0, 1'b1, 32'h0);
      check32("hold_status", obs_rdata, 32'h0000_0001);

      // Reset while a transfer is pending, followed by a stray ack.
      stall_mode = 1;
      op(1'b1, 1'b1, 1'b0, 32'h31);
      op(1'b1, 1'b1, 1'b0, 32'h32);
      op(1'b1, 1'b1, 1'b0, 32'h33);
      wait_stb();
      do_reset();
      check32("rst_mid_stb", {31'h0, con_stb}, 32'h0);
      op(1'b1, 1'b0, 1'b1, 32'h0);
      check32("rst_mid_status", obs_rdata, 32'h0000_0001);
      stall_mode = 0;
      force_ack  = 1'b1;
      idle();
      force_ack  = 1'b0;
      op(1'b1, 1'b0, 1'b1, 32'h0);
      check32("late_ack_status", obs_rdata, 32'h0000_0001);
      check32("late_ack_stb", {31'h0, con_stb}, 32'h0);

      // Random traffic against the scoreboard.
      stall_mode = 2;
      ack_max    = 3;
      for (int i = 0; i < 500; i++) begin
         int r;
         r = $urandom_range(99, 0);
         if (r < 50)
            op(1'b1, 1'b1, 1'b0, $urandom());
         else if (r < 75)
            op(1'b1, 1'b0, 1'b1, 32'h0);
         else if (r < 85)
            op(1'b1, 1'b0, 1'b0, 32'h0);
         else if (r < 90)
            op(1'b1, 1'b1, 1'b1, $urandom());
         else
            idle();
      end
      drain();
      op(1'b1, 1'b0, 1'b1, 32'h0);
      check32("final_status_empty", obs_rdata & 32'h0000_FF01, 32'h0000_0001);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
